// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use stall, branch flush and data-memory freeze with watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       Rs1d,
   input  logic [4:0]       Rs2d,
   input  logic [4:0]       Rs1e,
   input  logic [4:0]       Rs2e,
   input  logic [4:0]       Rde,
   input  logic             Resultsrce0,
   input  logic             Pcsrce,
   input  logic [4:0]       Rdm,
   input  logic [4:0]       Rdw,
   input  logic             Regwritem,
   input  logic             Regwritew,
   input  logic             Dmem_req,
   input  logic             Dmem_ready,
   output logic [1:0]       Forwardae,
   output logic [1:0]       Forwardbe,
   output logic             Stallf,
   output logic             Stalld,
   output logic             Stalle,
   output logic             Stallm,
   output logic             Flushd,
   output logic             Flushe,
   output logic             Flushw,
   output logic             Mem_err,
   output logic [CNT_W-1:0] Stall_cnt,
   output logic [CNT_W-1:0] Flush_cnt
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERR     = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                lwstall, memwait;
   logic                freeze, resolve;
   logic                stall_fd, flush_d, flush_e;
   logic [1:0]          fwd_a, fwd_b;

   assign lwstall = Resultsrce0 && (Rde != 5'd0) && ((Rde == Rs1d) || (Rde == Rs2d));
   assign memwait = Dmem_req && !Dmem_ready;

   // M stage result is younger than W, so it wins; x0 always reads as zero.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (Regwritem && (Rdm != 5'd0) && (Rdm == Rs1e))      fwd_a = 2'b10;
      else if (Regwritew && (Rdw != 5'd0) && (Rdw == Rs1e)) fwd_a = 2'b01;
      if (Regwritem && (Rdm != 5'd0) && (Rdm == Rs2e))      fwd_b = 2'b10;
      else if (Regwritew && (Rdw != 5'd0) && (Rdw == Rs2e)) fwd_b = 2'b01;
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      freeze  = 1'b0;
      resolve = 1'b0;
      case (state_q)
         RUN: begin
            if (memwait) begin
               freeze  = 1'b1;
               state_d = MEMWAIT;
               wcnt_d  = WCNT_W'(1);
            end else begin
               resolve = 1'b1;
            end
         end
         MEMWAIT: begin
            if (memwait) begin
               freeze = 1'b1;
               if (wcnt_q == WCNT_W'(MEM_TIMEOUT - 1)) state_d = ERR;
               else                                     wcnt_d  = wcnt_q + WCNT_W'(1);
            end else begin
               // Ready or request withdrawn: release cycle, held branch/load-use resolve now.
               resolve = 1'b1;
               state_d = RUN;
               wcnt_d  = '0;
            end
         end
         ERR: begin
            freeze = 1'b1;
         end
         default: begin
            state_d = RUN;
            wcnt_d  = '0;
         end
      endcase
   end

   // A taken branch must redirect the PC, so it overrides the load-use hold.
   always_comb begin
      stall_fd = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      if (resolve) begin
         stall_fd = lwstall && !Pcsrce;
         flush_d  = Pcsrce;
         flush_e  = lwstall || Pcsrce;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign Forwardae = rst_n ? fwd_a : 2'b00;
   assign Forwardbe = rst_n ? fwd_b : 2'b00;
   assign Stallf    = rst_n && (freeze || stall_fd);
   assign Stalld    = rst_n && (freeze || stall_fd);
   assign Stalle    = rst_n && freeze;
   assign Stallm    = rst_n && freeze;
   assign Flushd    = rst_n && flush_d;
   assign Flushe    = rst_n && flush_e;
   assign Flushw    = rst_n && freeze;
   assign Mem_err   = (state_q == ERR);

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (Stallf && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (Flushd && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign Stall_cnt = stall_cnt_q;
   assign Flush_cnt = flush_cnt_q;
`else
   assign Stall_cnt = '0;
   assign Flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal checks followed by randomized traffic against a per-cycle reference model.
module tb_hazard_ctrl;

   localparam int MEM_TIMEOUT = 16;
   localparam int CNT_W       = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       Rs1d, Rs2d, Rs1e, Rs2e, Rde, Rdm, Rdw;
   logic             Resultsrce0, Pcsrce, Regwritem, Regwritew, Dmem_req, Dmem_ready;
   logic [1:0]       Forwardae, Forwardbe;
   logic             Stallf, Stalld, Stalle, Stallm, Flushd, Flushe, Flushw, Mem_err;
   logic [CNT_W-1:0] Stall_cnt, Flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
     .clk(clk), .rst_n(rst_n),
     .Rs1d(Rs1d), .Rs2d(Rs2d), .Rs1e(Rs1e), .Rs2e(Rs2e), .Rde(Rde),
     .Resultsrce0(Resultsrce0), .Pcsrce(Pcsrce),
     .Rdm(Rdm), .Rdw(Rdw), .Regwritem(Regwritem), .Regwritew(Regwritew),
     .Dmem_req(Dmem_req), .Dmem_ready(Dmem_ready),
     .Forwardae(Forwardae), .Forwardbe(Forwardbe),
     .Stallf(Stallf), .Stalld(Stalld), .Stalle(Stalle), .Stallm(Stallm),
     .Flushd(Flushd), .Flushe(Flushe), .Flushw(Flushw),
     .Mem_err(Mem_err), .Stall_cnt(Stall_cnt), .Flush_cnt(Flush_cnt)
   );

   always #5 clk = ~clk;

   // {Stallf, Stalld, Stalle, Stallm, Flushd, Flushe, Flushw}
   wire [6:0] ctl = {Stallf, Stalld, Stalle, Stallm, Flushd, Flushe, Flushw};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
     n_cmp++;
     if (act !== exp) begin
       n_bad++;
       $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
     end
   endtask

   task automatic step();
     @(posedge clk);
     #1;
   endtask

   task automatic idle();
     {Rs1d, Rs2d, Rs1e, Rs2e, Rde, Rdm, Rdw} = '0;
     {Resultsrce0, Pcsrce, Regwritem, Regwritew, Dmem_req, Dmem_ready} = '0;
   endtask

   // ---------------- reference model ----------------
   int        m_wait, m_sc, m_fc;
   bit        m_err;
   logic [6:0] e_ctl;
   logic [1:0] e_fa, e_fb;
   logic       e_lw, e_mw, e_sfd;
   int         e_sc, e_fc;

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
     if (Regwritem && Rdm != 0 && Rdm == rs) return 2'b10;
     if (Regwritew && Rdw != 0 && Rdw == rs) return 2'b01;
     return 2'b00;
   endfunction

   always @(negedge clk) begin
     if (!rst_n) begin
       m_err = 0; m_wait = 0; m_sc = 0; m_fc = 0;
       e_ctl = '0; e_fa = '0; e_fb = '0;
     end else begin
       e_lw = Resultsrce0 && Rde != 0 && (Rde == Rs1d || Rde == Rs2d);
       e_mw = Dmem_req && !Dmem_ready;
       e_fa = exp_fwd(Rs1e);
       e_fb = exp_fwd(Rs2e);
       if (m_err || e_mw) e_ctl = 7'b1111001;
       else begin
         e_sfd = e_lw && !Pcsrce;
         e_ctl = {e_sfd, e_sfd, 2'b00, Pcsrce, e_lw || Pcsrce, 1'b0};
       end
     end
`ifdef HAZARD_PERF_CNT_EN
     e_sc = m_sc; e_fc = m_fc;
`else
     e_sc = 0; e_fc = 0;
`endif
     check("ctl", 32'(ctl), 32'(e_ctl));
     check("fwd_a", 32'(Forwardae), 32'(e_fa));
     check("fwd_b", 32'(Forwardbe), 32'(e_fb));
     check("mem_err", 32'(Mem_err), 32'(m_err));
     check("stall_cnt", 32'(Stall_cnt), 32'(e_sc));
     check("flush_cnt", 32'(Flush_cnt), 32'(e_fc));
     if (rst_n) begin
       if (e_ctl[6] && m_sc != CNT_MAX) m_sc++;
       if (e_ctl[2] && m_fc != CNT_MAX) m_fc++;
       if (!m_err) begin
         if (e_mw) begin
           m_wait++;
           if (m_wait == MEM_TIMEOUT) m_err = 1;
         end else m_wait = 0;
       end
     end
   end

   // ---------------- stimulus ----------------
   int slow;

   initial begin
     idle();
     rst_n = 1'b0;
     Rs1e = 5; Rdm = 5; Regwritem = 1'b1; Resultsrce0 = 1'b1; Rde = 3; Rs1d = 3;
     #2;
     check("rst_fwd", 32'(Forwardae), 32'd0);
     check("rst_ctl", 32'(ctl), 32'd0);
     check("rst_err", 32'(Mem_err), 32'd0);
     step(); step();
     idle();
     rst_n = 1'b1;

     // forwarding priority and x0
     Rs1e = 5; Rs2e = 5; Rdm = 5; Regwritem = 1; Rdw = 5; Regwritew = 1;
     #1;
     check("fwd_m_a", 32'(Forwardae), 32'd2);
     check("fwd_m_b", 32'(Forwardbe), 32'd2);
     step();
     Regwritem = 0;
     #1 check("fwd_w_a", 32'(Forwardae), 32'd1);
     step();
     Rs1e = 0; Rdm = 0; Rdw = 0; Regwritem = 1;
     #1 check("fwd_x0", 32'(Forwardae), 32'd0);

     // load-use, then load-use with taken branch
     step(); idle();
     Resultsrce0 = 1; Rde = 7; Rs2d = 7;
     #1 check("lw_stall", 32'(ctl), 32'b1100010);
     step();
     Pcsrce = 1;
     #1 check("lw_branch", 32'(ctl), 32'b0000110);

     // three-cycle memory wait then release
     step(); idle();
     Dmem_req = 1;
     for (int i = 0; i < 3; i++) begin
       if (i > 0) step();
       #1 check("memwait", 32'(ctl), 32'b1111001);
     end
     step();
     Dmem_ready = 1;
     #1 check("mem_release", 32'(ctl), 32'd0);
     step(); idle();
     #1 check("mem_noerr", 32'(Mem_err), 32'd0);

     // branch held across a two-cycle wait
     step();
     Dmem_req = 1; Pcsrce = 1;
     #1 check("br_wait0", 32'(ctl), 32'b1111001);
     step();
     #1 check("br_wait1", 32'(ctl), 32'b1111001);
     step();
     Dmem_ready = 1;
     #1 check("br_release", 32'(ctl), 32'b0000110);

     // watchdog timeout into sticky error
     step(); idle();
     Dmem_req = 1;
     #1 check("to_err0", 32'(Mem_err), 32'd0);
     for (int i = 1; i < MEM_TIMEOUT; i++) begin
       step();
       #1 check("to_err_pre", 32'(Mem_err), 32'd0);
     end
     step();
     #1 check("to_err_set", 32'(Mem_err), 32'd1);
     Dmem_ready = 1;
     for (int i = 0; i < 6; i++) begin
       step();
       #1 check("err_hold", 32'(ctl), 32'b1111001);
       check("err_sticky", 32'(Mem_err), 32'd1);
     end
`ifdef HAZARD_PERF_CNT_EN
     check("stall_sat", 32'(Stall_cnt), 32'd15);
`else
     check("stall_zero", 32'(Stall_cnt), 32'd0);
`endif
     Rs1e = 9; Rdm = 9; Regwritem = 1;
     #1 rst_n = 1'b0;
     #1;
     check("async_err", 32'(Mem_err), 32'd0);
     check("async_ctl", 32'(ctl), 32'd0);
     check("async_fwd", 32'(Forwardae), 32'd0);
     check("async_cnt", 32'(Stall_cnt), 32'd0);
     step();
     idle();
     rst_n = 1'b1;

     // randomized traffic, with occasional slow-memory windows and reset pulses
     slow = 0;
     for (int c = 0; c < 4000; c++) begin
       step();
       if (!rst_n) rst_n = 1'b1;
       else if ($urandom_range(0, 249) == 0) rst_n = 1'b0;
       Rs1d = 5'($urandom_range(0, 3)); Rs2d = 5'($urandom_range(0, 3));
       Rs1e = 5'($urandom_range(0, 3)); Rs2e = 5'($urandom_range(0, 3));
       Rde  = 5'($urandom_range(0, 3)); Rdm  = 5'($urandom_range(0, 3));
       Rdw  = 5'($urandom_range(0, 3));
       Resultsrce0 = 1'($urandom_range(0, 1));
       Pcsrce      = ($urandom_range(0, 3) == 0);
       Regwritem   = 1'($urandom_range(0, 1));
       Regwritew   = 1'($urandom_range(0, 1));
       if (slow == 0 && $urandom_range(0, 299) == 0) slow = $urandom_range(10, 24);
       Dmem_req = (slow > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
       Dmem_ready = (slow > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
       if (slow > 0) slow--;
     end

     step();
     $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
     $finish;
   end

endmodule
